// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
//   Shared definitions for the PLL lock controller: the FSM state encoding
//   (also exported on ctrl_state, so the numeric values are fixed) and a
//   helper that sizes the shared cycle counter from the timing parameters.
package pll_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_t;

  // Wide enough to hold the largest of the three cycle limits, plus one
  // bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Generic two-flop synchroniser for bringing asynchronous level signals
//   into the clk domain. Both stages clear to 0 on reset.
//
// Ports
//   clk    destination clock
//   rst_n  asynchronous active-low reset
//   d      asynchronous input
//   q      synchronised output (two clk cycles of latency)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; only the second stage is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
//   Brings the system PLL from power-up to a usable state. Holds the PLL in
//   reset, waits for a synchronised lock, requires lock to hold for a
//   stable period, then releases the downstream reset. Loss of lock or a
//   lock timeout re-resets the PLL; too many consecutive failures park the
//   controller in FAIL until restart or sys_rst_n.
//
// Ports
//   sys_clk     50 MHz system clock
//   sys_rst_n   asynchronous active-low reset
//   pll_locked  PLL locked flag, asynchronous to sys_clk
//   restart     single-cycle request to re-run the sequence from RESET
//   pll_areset  active-high PLL reset (registered)
//   pll_rst_n   active-low reset for PLL-clocked logic (registered)
//   ctrl_state  current FSM state
//   retry_cnt   failed attempts since last RUN or reset (saturating)
//   pll_fail    sticky failure flag
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 10,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1000,
  parameter int MAX_RETRY     = 3
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_areset,
  output logic               pll_rst_n,
  output logic [STATE_W-1:0] ctrl_state,
  output logic [1:0]         retry_cnt,
  output logic               pll_fail
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  // The counter starts at 0 on state entry, so "N cycles spent" is reached
  // when the counter shows N-1 during the last of those cycles.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

  pll_state_t       state;
  pll_state_t       next_state;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;
  logic             retry_event;
  logic [1:0]       retry_inc;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  assign ctrl_state = state;

  // Next-state decision. Lock is tested before the timeout in WAIT_LOCK so
  // a lock arriving on the timeout cycle still wins. A retry event picks
  // RESET or FAIL from the post-increment count, and restart overrides
  // everything.
  always_comb begin
    next_state  = state;
    retry_event = 1'b0;
    case (state)
      ST_RESET: begin
        if (cnt == RST_LAST) next_state = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s)                   next_state  = ST_STABLE;
        else if (cnt == TIMEOUT_LAST) retry_event = 1'b1;
      end
      ST_STABLE: begin
        if (!lock_s)                 retry_event = 1'b1;
        else if (cnt == STABLE_LAST) next_state  = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) retry_event = 1'b1;
      end
      ST_FAIL: begin
        next_state = ST_FAIL;
      end
      default: begin
        next_state = ST_RESET;
      end
    endcase

    retry_inc = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + 2'd1;
    if (retry_event) next_state = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET;
    if (restart)     next_state = ST_RESET;
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_RESET;
    else            state <= next_state;
  end

  // Counter, retry bookkeeping and outputs. Outputs are decoded from
  // next_state and registered so they line up with the state register and
  // never glitch. The counter idles at 0 in RUN and FAIL, which have no
  // time limit; a restart counts as a transition even from RESET.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt        <= '0;
      retry_cnt  <= '0;
      pll_areset <= 1'b1;
      pll_rst_n  <= 1'b0;
      pll_fail   <= 1'b0;
    end else begin
      if (restart || (next_state != state) || (state == ST_RUN) || (state == ST_FAIL))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if (restart)
        retry_cnt <= '0;
      else if ((next_state == ST_RUN) && (state != ST_RUN))
        retry_cnt <= '0;
      else if (retry_event)
        retry_cnt <= retry_inc;

      pll_areset <= (next_state == ST_RESET) || (next_state == ST_FAIL);
      pll_rst_n  <= (next_state == ST_RUN);
      pll_fail   <= (next_state == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl
//   Bench for pll_lock_ctrl with short timing parameters. A behavioural
//   model tracks which phase the sequencer should be in and how long it has
//   been there; a compare process checks every DUT output against it on
//   each falling edge. Directed scenarios pin exact cycle counts, followed
//   by a randomized lock/restart pattern.
module tb_pll_lock_ctrl;

  localparam int RST_CYCLES    = 10;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int STABLE_CYCLES = 20;
  localparam int MAX_RETRY     = 3;

  localparam int PH_RESET  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAIL   = 4;

  localparam int P_ARESET = 0;
  localparam int P_RSTN   = 1;
  localparam int P_FAIL   = 2;
  localparam int P_STABLE = 3;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_areset;
  logic       pll_rst_n;
  logic [2:0] ctrl_state;
  logic [1:0] retry_cnt;
  logic       pll_fail;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  // Model: phase, cycles spent in it, failed attempts, and the lock history
  // the sequencer can see (two edges behind the pin).
  int m_phase;
  int m_elapsed;
  int m_fails;
  bit m_lock_q[$];

  pll_lock_ctrl #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_areset (pll_areset),
    .pll_rst_n  (pll_rst_n),
    .ctrl_state (ctrl_state),
    .retry_cnt  (retry_cnt),
    .pll_fail   (pll_fail)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      if (miscompares <= 40)
        $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit locked, input bit restart_req);
    @(negedge sys_clk);
    pll_locked = locked;
    restart    = restart_req;
  endtask

  task automatic model_enter(input int ph);
    m_phase   = ph;
    m_elapsed = 0;
  endtask

  task automatic model_reset();
    m_lock_q.delete();
    m_lock_q.push_back(1'b0);
    m_lock_q.push_back(1'b0);
    m_fails = 0;
    model_enter(PH_RESET);
  endtask

  // One rising edge of the sequencer, stated in terms of elapsed time per
  // phase and the lock value seen at that edge.
  task automatic model_step();
    bit seen;
    bit retry;
    seen  = m_lock_q.pop_front();
    m_lock_q.push_back(pll_locked);
    m_elapsed++;
    retry = 1'b0;
    if (restart) begin
      m_fails = 0;
      model_enter(PH_RESET);
    end else begin
      case (m_phase)
        PH_RESET:  if (m_elapsed >= RST_CYCLES) model_enter(PH_WAIT);
        PH_WAIT: begin
          if (seen) model_enter(PH_STABLE);
          else if (m_elapsed >= LOCK_TIMEOUT) retry = 1'b1;
        end
        PH_STABLE: begin
          if (!seen) retry = 1'b1;
          else if (m_elapsed >= STABLE_CYCLES) begin
            m_fails = 0;
            model_enter(PH_RUN);
          end
        end
        PH_RUN:    if (!seen) retry = 1'b1;
        default:   ;
      endcase
      if (retry) begin
        m_fails++;
        model_enter((m_fails >= MAX_RETRY) ? PH_FAIL : PH_RESET);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) model_reset();
      else            model_step();
    end
  end

  initial begin
    wait (check_en);
    forever begin
      @(negedge sys_clk);
      checkOutput("ctrl_state", int'(ctrl_state), m_phase);
      checkOutput("pll_areset", int'(pll_areset), int'(m_phase == PH_RESET || m_phase == PH_FAIL));
      checkOutput("pll_rst_n",  int'(pll_rst_n),  int'(m_phase == PH_RUN));
      checkOutput("pll_fail",   int'(pll_fail),   int'(m_phase == PH_FAIL));
      checkOutput("retry_cnt",  int'(retry_cnt),  m_fails);
    end
  end

  function automatic bit probe(input int sel);
    case (sel)
      P_ARESET: return pll_areset;
      P_RSTN:   return pll_rst_n;
      P_FAIL:   return pll_fail;
      default:  return ctrl_state == 3'd2;
    endcase
  endfunction

  // Counts rising edges until the probed signal takes the wanted value;
  // returns -1 if the limit expires first.
  task automatic edges_until(input int sel, input bit val, input int limit, output int n);
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < limit) begin
      @(posedge sys_clk);
      #1;
      n++;
      if (probe(sel) == val) done = 1'b1;
    end
    if (!done) n = -1;
  endtask

  initial begin
    int n;
    bit lk;
    int hold;
    sys_rst_n  = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    #1 sys_rst_n = 1'b0;
    check_en = 1'b1;

    // Reset values
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_areset", int'(pll_areset), 1);
    checkOutput("rst_rst_n",  int'(pll_rst_n),  0);
    checkOutput("rst_state",  int'(ctrl_state), 0);
    checkOutput("rst_retry",  int'(retry_cnt),  0);
    checkOutput("rst_fail",   int'(pll_fail),   0);
    sys_rst_n = 1'b1;

    // Nominal bring-up
    edges_until(P_ARESET, 1'b0, 50, n);
    checkOutput("areset_high_cycles", n, 10);
    repeat (29) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    edges_until(P_RSTN, 1'b1, 200, n);
    checkOutput("lock_to_release", n, 23);
    checkOutput("nominal_state", int'(ctrl_state), 3);
    checkOutput("nominal_retry", int'(retry_cnt), 0);

    // Loss of lock in RUN
    applyStimulus(1'b0, 1'b0);
    edges_until(P_RSTN, 1'b0, 10, n);
    checkOutput("loss_to_rst_low", n, 3);
    checkOutput("loss_state", int'(ctrl_state), 0);
    checkOutput("loss_retry", int'(retry_cnt), 1);
    checkOutput("loss_areset", int'(pll_areset), 1);

    // Restart clears the retry count
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("restart_retry", int'(retry_cnt), 0);

    // Lock glitch during STABLE
    edges_until(P_ARESET, 1'b0, 50, n);
    checkOutput("restart_reset_len", n, 10);
    applyStimulus(1'b1, 1'b0);
    edges_until(P_STABLE, 1'b1, 50, n);
    checkOutput("lock_to_stable", n, 3);
    repeat (9) applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("glitch_state", int'(ctrl_state), 0);
    checkOutput("glitch_retry", int'(retry_cnt), 1);
    checkOutput("glitch_areset", int'(pll_areset), 1);
    edges_until(P_RSTN, 1'b1, 200, n);
    checkOutput("glitch_recover", n, 31);
    checkOutput("recover_retry", int'(retry_cnt), 0);

    // Never locks: three timeouts then FAIL
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    edges_until(P_FAIL, 1'b1, 1000, n);
    checkOutput("cycles_to_fail", n, 330);
    checkOutput("fail_state", int'(ctrl_state), 4);
    checkOutput("fail_retry", int'(retry_cnt), 3);
    repeat (200) applyStimulus(1'b0, 1'b0);
    checkOutput("fail_held_state", int'(ctrl_state), 4);
    checkOutput("fail_held_areset", int'(pll_areset), 1);
    checkOutput("fail_held_flag", int'(pll_fail), 1);

    // Restart from FAIL
    applyStimulus(1'b1, 1'b1);
    @(posedge sys_clk);
    #1;
    checkOutput("unfail_state", int'(ctrl_state), 0);
    checkOutput("unfail_flag", int'(pll_fail), 0);
    checkOutput("unfail_retry", int'(retry_cnt), 0);
    applyStimulus(1'b1, 1'b0);

    // Restart on the cycle STABLE would complete
    edges_until(P_STABLE, 1'b1, 100, n);
    checkOutput("restart_to_stable", n, 11);
    repeat (19) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    @(posedge sys_clk);
    #1;
    checkOutput("race_state", int'(ctrl_state), 0);
    checkOutput("race_rst_n", int'(pll_rst_n), 0);
    applyStimulus(1'b1, 1'b0);

    // Asynchronous reset mid-RUN
    edges_until(P_RSTN, 1'b1, 200, n);
    checkOutput("relock_release", n, 31);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    checkOutput("async_rst_n", int'(pll_rst_n), 0);
    checkOutput("async_areset", int'(pll_areset), 1);
    checkOutput("async_state", int'(ctrl_state), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Randomized lock pattern with occasional restarts
    for (int ep = 0; ep < 60; ep++) begin
      lk   = ($urandom_range(0, 3) != 0);
      hold = lk ? int'($urandom_range(5, 150)) : int'($urandom_range(1, 130));
      for (int c = 0; c < hold; c++)
        applyStimulus(lk, ($urandom_range(0, 199) == 0));
    end
    applyStimulus(1'b0, 1'b0);
    repeat (5) @(negedge sys_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
